// File: rtl/cluster_clock_gate_ctrl.sv
// cluster_clock_gate_ctrl
//
// Per-channel clock-gate sequencer for the cluster. Each of NB_CH gated
// domains gets an independent OFF/WAKE/ON/IDLE sequencer. The sequencer
// raises the clock-AND enable when there is activity. It waits WAKE_CYCLES
// before reporting the domain usable. It keeps the clock running for
// IDLE_CYCLES of consecutive inactivity before dropping the enable again.
//
// Optional feature macro: CLUSTER_CLK_GATE_STATS_EN
//   When defined, this adds per-channel 32-bit saturating counters of the
//   cycles spent in OFF. They are exported on gated_cnt_o.
//
// Ports:
//   clk_i        free-running ungated cluster clock
//   rst_ni       synchronous active-low reset
//   test_mode_i  DFT override, forces every clk_en_o bit high (combinational)
//   force_on_i   [NB_CH] software keep-alive per channel
//   busy_i       [NB_CH] domain has outstanding work
//   wake_req_i   [NB_CH] external wake request (event/IRQ)
//   clk_en_o     [NB_CH] enable to each channel's clock-AND gate
//   ready_o      [NB_CH] channel clocked and settled
//   gated_cnt_o  [NB_CH*32] OFF-cycle counters, channel i at [32i+31:32i]
//                (present only with CLUSTER_CLK_GATE_STATS_EN)

module cluster_clock_gate_ctrl #(
  parameter int NB_CH       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic [NB_CH-1:0]    force_on_i,
  input  logic [NB_CH-1:0]    busy_i,
  input  logic [NB_CH-1:0]    wake_req_i,
  output logic [NB_CH-1:0]    clk_en_o,
  output logic [NB_CH-1:0]    ready_o
`ifdef CLUSTER_CLK_GATE_STATS_EN
  ,
  output logic [NB_CH*32-1:0] gated_cnt_o
`endif
);

  localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  logic [NB_CH-1:0] act;

  assign act = busy_i | wake_req_i | force_on_i;

  for (genvar g = 0; g < NB_CH; g++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            if (act[g]) begin
              state_q <= ST_WAKE;
              cnt_q   <= WAKE_LOAD;
            end
          end
          // A wake always runs to completion, even if activity drops.
          // This keeps the gate from toggling while the clock settles.
          ST_WAKE: begin
            if (cnt_q == '0) begin
              state_q <= ST_ON;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_ON: begin
            if (!act[g]) begin
              state_q <= ST_IDLE;
              cnt_q   <= IDLE_LOAD;
            end
          end
          // Activity is checked before expiry. Work that arrives on the
          // last idle cycle keeps the domain clocked.
          ST_IDLE: begin
            if (act[g]) begin
              state_q <= ST_ON;
            end else if (cnt_q == '0) begin
              state_q <= ST_OFF;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    // Both outputs decode the state register. The only combinational
    // input path is the DFT override on the enable.
    assign clk_en_o[g] = (state_q != ST_OFF) | test_mode_i;
    assign ready_o[g]  = (state_q == ST_ON) || (state_q == ST_IDLE);

`ifdef CLUSTER_CLK_GATE_STATS_EN
    logic [31:0] off_cnt_q;

    // The count follows the FSM state only, so test mode does not stop it.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        off_cnt_q <= '0;
      end else if ((state_q == ST_OFF) && (off_cnt_q != 32'hFFFF_FFFF)) begin
        off_cnt_q <= off_cnt_q + 32'd1;
      end
    end

    assign gated_cnt_o[32*g +: 32] = off_cnt_q;
`endif
  end

endmodule
